// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family.
// Holds the default pattern parameters, the upper bound on pattern length
// and a ceiling-log2 helper used to size the history fill counter.
package seq_det_pkg;

    localparam int unsigned DEF_PAT_LEN = 4;
    localparam logic [3:0]  DEF_PATTERN = 4'b0110;
    localparam int unsigned MAX_PAT_LEN = 32;

    // Bits needed to represent 0..value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active low
//   inc    in   increment request (ignored once all-ones)
//   clr    in   synchronous clear, has priority over inc
//   count  out  current count
//   sat    out  registered flag, high while count is all-ones
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            // Registered alongside count so both change on the same edge.
            sat_q   <= (count_d == '1);
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_pattern_det.sv
// Serial sync-word detector: shifts in one bit per enabled cycle and pulses
// match when the last PAT_LEN consumed bits equal PATTERN (MSB received first).
// Overlapping or restart-after-match detection, plus a saturating match count.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   en         in   din is valid and consumed this cycle
//   din        in   serial data bit
//   clr        in   synchronous clear of history and counter; beats en
//   match      out  one-cycle pulse after the edge that completed the pattern
//   match_cnt  out  matches since reset/clr, saturating
//   cnt_sat    out  high while match_cnt is all-ones
module seq_pattern_det
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned FW = clog2(PAT_LEN + 1);

    if ((PAT_LEN < 2) || (PAT_LEN > MAX_PAT_LEN) || (CNT_W < 1)) begin : g_bad_param
        $error("seq_pattern_det: PAT_LEN must be 2..32 and CNT_W >= 1");
    end

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               match_q, match_d;
    logic [PAT_LEN-1:0] nxt;
    logic               hit;
    logic               unused_hist_msb;

    // The oldest history bit falls off the end on every shift.
    assign unused_hist_msb = hist_q[PAT_LEN-1];

    assign nxt = {hist_q[PAT_LEN-2:0], din};
    // fill gates out stale zeros left by reset/clr, so PATTERN=0 is safe.
    assign hit = en && (fill_q >= FW'(PAT_LEN - 1)) && (nxt == PATTERN);

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d  = nxt;
            match_d = hit;
            if (hit && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_q < FW'(PAT_LEN)) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (clr),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

    assign match = match_q;

endmodule

// File: tb/tb_seq_pattern_det.sv
// Directed bench for seq_pattern_det. Three instances share one stimulus stream:
//   a: default (0110, overlapping, 8-bit count)
//   b: 0110, non-overlapping
//   c: 0000, overlapping, 2-bit count for saturation
module tb_seq_pattern_det;

    logic clk;
    logic rst_n;
    logic en;
    logic din;
    logic clr;

    logic       match_a, match_b, match_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_c;

    int total;
    int bad;

    seq_pattern_det u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .clr       (clr),
        .match     (match_a),
        .match_cnt (cnt_a),
        .cnt_sat   (sat_a)
    );

    seq_pattern_det #(
        .PAT_LEN (4),
        .PATTERN (4'b0110),
        .OVERLAP (1'b0),
        .CNT_W   (8)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .clr       (clr),
        .match     (match_b),
        .match_cnt (cnt_b),
        .cnt_sat   (sat_b)
    );

    seq_pattern_det #(
        .PAT_LEN (4),
        .PATTERN (4'b0000),
        .OVERLAP (1'b1),
        .CNT_W   (2)
    ) u_dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .clr       (clr),
        .match     (match_c),
        .match_cnt (cnt_c),
        .cnt_sat   (sat_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic drive(input logic r, input logic e, input logic d, input logic c);
        rst_n = r;
        en    = e;
        din   = d;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("clr_cnt_a", 32'(cnt_a), 32'd0);
        check_val("clr_cnt_b", 32'(cnt_b), 32'd0);
        check_val("clr_cnt_c", 32'(cnt_c), 32'd0);
    endtask

    initial begin
        logic [6:0] stream;
        logic [6:0] exp_a;
        logic [6:0] exp_b;
        logic [3:0] pat4;
        logic [2:0] exp_c;
        int         n_pulse;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        clr   = 1'b0;

        // 1. Reset held with en=1 and toggling data.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'(i % 2), 1'b0);
            check_val("rst_match", 32'(match_a), 32'd0);
            check_val("rst_cnt", 32'(cnt_a), 32'd0);
            check_val("rst_sat", 32'(sat_a), 32'd0);
        end
        // First 3 bits after release: 0,1,1 is a 0110 prefix but must not match.
        pat4 = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, pat4[3-i], 1'b0);
            check_val("post_rst_match", 32'(match_a), 32'd0);
        end
        // Reset mid-sequence aborts: the trailing 0 must not complete 0110.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("rst_abort_match", 32'(match_a), 32'd0);
        check_val("rst_abort_cnt", 32'(cnt_a), 32'd0);
        clear_all();

        // 2/3. Stream 0110110: overlap hits on bits 4 and 7, non-overlap only bit 4.
        stream = 7'b0110110;
        exp_a  = 7'b0001001;  // index = bit position 0..6
        exp_b  = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, stream[6-i], 1'b0);
            check_val($sformatf("ovl_match_%0d", i), 32'(match_a), 32'(exp_a[6-i]));
            check_val($sformatf("novl_match_%0d", i), 32'(match_b), 32'(exp_b[6-i]));
        end
        check_val("ovl_cnt", 32'(cnt_a), 32'd2);
        check_val("novl_cnt", 32'(cnt_b), 32'd1);
        check_val("ovl_sat", 32'(sat_a), 32'd0);
        clear_all();

        // 4. Gapped input: 0,1,1,0 with two idle cycles after each bit.
        n_pulse = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, pat4[3-i], 1'b0);
            check_val($sformatf("gap_match_%0d", i), 32'(match_a), 32'(i == 3));
            for (int g = 0; g < 2; g++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                check_val("gap_idle_match", 32'(match_a), 32'd0);
            end
        end
        check_val("gap_cnt", 32'(cnt_a), 32'd1);
        clear_all();

        // 5. clr/en collision swallows the final 0 of 0110.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, pat4[3-i], 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check_val("coll_match", 32'(match_a), 32'd0);
        check_val("coll_cnt", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, pat4[3-i], 1'b0);
            check_val($sformatf("coll_after_%0d", i), 32'(match_a), 32'(i == 3));
        end
        check_val("coll_final_cnt", 32'(cnt_a), 32'd1);
        clear_all();

        // 6. Ten zeros into the 0000 / 2-bit-count instance.
        exp_c = 3'd0;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            if (i >= 4 && exp_c < 3'd3) exp_c = exp_c + 3'd1;
            check_val($sformatf("sat_match_%0d", i), 32'(match_c), 32'(i >= 4));
            check_val($sformatf("sat_cnt_%0d", i), 32'(cnt_c), 32'(exp_c));
            check_val($sformatf("sat_flag_%0d", i), 32'(sat_c), 32'(i >= 6));
            check_val("zeros_a_match", 32'(match_a), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("sat_clr_cnt", 32'(cnt_c), 32'd0);
        check_val("sat_clr_flag", 32'(sat_c), 32'd0);
        check_val("sat_clr_match", 32'(match_c), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
